// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the DMEM bus branch (M0 = CPU data, M1 = DMA).
// Bounded bursts, zero-latency grant, registered single-cycle read return.
module dmem_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_we,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_we,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST - 1);

    if (MAX_BURST == 0) begin : g_param_check
        $error("dmem_arbiter: MAX_BURST must be at least 1");
    end

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_M0   = 2'd1,
        SEL_M1   = 2'd2
    } sel_e;

    sel_e             owner, owner_n;
    sel_e             last, last_n;
    sel_e             rsel, rsel_n;
    sel_e             win;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_n;
    logic [31:0]      rdata_q, rdata_n;

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner    <= SEL_NONE;
            last     <= SEL_M1;
            beat_cnt <= '0;
            rsel     <= SEL_NONE;
            rdata_q  <= '0;
        end else begin
            owner    <= owner_n;
            last     <= last_n;
            beat_cnt <= beat_cnt_n;
            rsel     <= rsel_n;
            rdata_q  <= rdata_n;
        end
    end

    // Winner selection and next state; nothing is granted while reset is asserted
    always_comb begin
        win        = SEL_NONE;
        owner_n    = owner;
        last_n     = last;
        beat_cnt_n = beat_cnt;
        rsel_n     = SEL_NONE;
        rdata_n    = rdata_q;

        if (!reset) begin
            win = SEL_NONE;
        end else if (owner == SEL_M0 && m0_req && (!m1_req || beat_cnt < CNT_MAX)) begin
            win = SEL_M0;
        end else if (owner == SEL_M1 && m1_req && (!m0_req || beat_cnt < CNT_MAX)) begin
            win = SEL_M1;
        end else if (m0_req && m1_req) begin
            win = (last == SEL_M0) ? SEL_M1 : SEL_M0;
        end else if (m0_req) begin
            win = SEL_M0;
        end else if (m1_req) begin
            win = SEL_M1;
        end

        if (win == SEL_NONE) begin
            owner_n    = SEL_NONE;
            beat_cnt_n = '0;
        end else begin
            owner_n = win;
            last_n  = win;
            if (owner == win) begin
                beat_cnt_n = (beat_cnt >= CNT_MAX) ? CNT_MAX : beat_cnt + CNT_W'(1);
            end else begin
                beat_cnt_n = '0;
            end
            if ((win == SEL_M0 && m0_we == 4'h0) || (win == SEL_M1 && m1_we == 4'h0)) begin
                rsel_n  = win;
                rdata_n = mem_rdata;
            end
        end
    end

    // Bus mux, grants and read return
    always_comb begin
        m0_gnt    = 1'b0;
        m1_gnt    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 4'h0;

        case (win)
            SEL_M0: begin
                m0_gnt    = 1'b1;
                mem_addr  = m0_addr;
                mem_wdata = m0_wdata;
                mem_we    = m0_we;
            end
            SEL_M1: begin
                m1_gnt    = 1'b1;
                mem_addr  = m1_addr;
                mem_wdata = m1_wdata;
                mem_we    = m1_we;
            end
            default: ;
        endcase

        m0_rvalid = (rsel == SEL_M0);
        m1_rvalid = (rsel == SEL_M1);
        m0_rdata  = m0_rvalid ? rdata_q : '0;
        m1_rdata  = m1_rvalid ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_BURST=4 and 1) on shared master stimulus,
// checked against a streak-counting reference model plus directed scenarios.
module tb_dmem_arbiter;

    localparam int unsigned MB0 = 4;
    localparam int unsigned MB1 = 1;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_we, m1_we;

    logic        g0 [2];
    logic        g1 [2];
    logic        rv0 [2];
    logic        rv1 [2];
    logic [31:0] rd0 [2];
    logic [31:0] rd1 [2];
    logic [31:0] maddr [2];
    logic [31:0] mwd [2];
    logic [3:0]  mwe [2];
    logic [31:0] mrd [2];

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    // reference model state: 0 = none, 1 = M0, 2 = M1
    int          own [2];
    int          lst [2];
    int          streak [2];
    int          pend [2];
    logic [31:0] pdata [2];
    bit          known [2];
    int          lastw [2];

    function automatic logic [31:0] dev(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h1234, a[31:16]} + 32'h9E37_79B9;
    endfunction

    assign mrd[0] = dev(maddr[0]);
    assign mrd[1] = dev(maddr[1]);

    dmem_arbiter #(.MAX_BURST(MB0)) dut0 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]),
        .mem_addr(maddr[0]), .mem_wdata(mwd[0]), .mem_we(mwe[0]), .mem_rdata(mrd[0])
    );

    dmem_arbiter #(.MAX_BURST(MB1)) dut1 (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_we(m0_we),
        .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_we(m1_we),
        .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]),
        .mem_addr(maddr[1]), .mem_wdata(mwd[1]), .mem_we(mwe[1]), .mem_rdata(mrd[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    // A master keeps the bus while its streak is below the burst limit or the other is idle
    function automatic int model_win(input int k);
        int mb;
        bit r [3];
        mb   = (k == 0) ? int'(MB0) : int'(MB1);
        r[0] = 1'b0;
        r[1] = m0_req;
        r[2] = m1_req;
        if (!reset) return 0;
        if (own[k] != 0 && r[own[k]] && (!r[3 - own[k]] || streak[k] < mb)) return own[k];
        if (m0_req && m1_req) return 3 - lst[k];
        if (m0_req) return 1;
        if (m1_req) return 2;
        return 0;
    endfunction

    task automatic drive(input logic rs,
                         input logic q0, input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] e0,
                         input logic q1, input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] e1);
        reset    = rs;
        m0_req   = q0; m0_addr = a0; m0_wdata = d0; m0_we = e0;
        m1_req   = q1; m1_addr = a1; m1_wdata = d1; m1_we = e1;
        #2;
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic [31:0] ea, ed;
            logic [3:0]  ee;
            w  = model_win(k);
            ea = (w == 1) ? m0_addr  : (w == 2) ? m1_addr  : 32'h0;
            ed = (w == 1) ? m0_wdata : (w == 2) ? m1_wdata : 32'h0;
            ee = (w == 1) ? m0_we    : (w == 2) ? m1_we    : 4'h0;
            check($sformatf("dut%0d c%0d m0_gnt", k, cyc), 32'(g0[k]), 32'(w == 1));
            check($sformatf("dut%0d c%0d m1_gnt", k, cyc), 32'(g1[k]), 32'(w == 2));
            check($sformatf("dut%0d c%0d mem_addr", k, cyc), maddr[k], ea);
            check($sformatf("dut%0d c%0d mem_wdata", k, cyc), mwd[k], ed);
            check($sformatf("dut%0d c%0d mem_we", k, cyc), 32'(mwe[k]), 32'(ee));
            if (known[k]) begin
                check($sformatf("dut%0d c%0d m0_rvalid", k, cyc), 32'(rv0[k]), 32'(pend[k] == 1));
                check($sformatf("dut%0d c%0d m1_rvalid", k, cyc), 32'(rv1[k]), 32'(pend[k] == 2));
                check($sformatf("dut%0d c%0d m0_rdata", k, cyc), rd0[k], (pend[k] == 1) ? pdata[k] : 32'h0);
                check($sformatf("dut%0d c%0d m1_rdata", k, cyc), rd1[k], (pend[k] == 2) ? pdata[k] : 32'h0);
            end
            lastw[k] = w;
            if (!reset) begin
                own[k] = 0; lst[k] = 2; streak[k] = 0; pend[k] = 0; known[k] = 1'b1;
            end else if (w == 0) begin
                own[k] = 0; streak[k] = 0; pend[k] = 0;
            end else begin
                streak[k] = (own[k] == w) ? streak[k] + 1 : 1;
                own[k]    = w;
                lst[k]    = w;
                if (ee == 4'h0) begin
                    pend[k]  = w;
                    pdata[k] = dev(ea);
                end else begin
                    pend[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        logic        q0, q1;
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  e0, e1;
        int          p0, p1;

        known = '{1'b0, 1'b0};

        // reset held with both masters reading: no grant, no bus write
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 32'h200, 32'h0, 4'h0, 1'b1, 32'h300, 32'h0, 4'h0);
            check($sformatf("rst%0d gnt", i), 32'({g0[0], g1[0], g0[1], g1[1]}), 32'h0);
            check($sformatf("rst%0d mem_we", i), 32'(mwe[0]), 32'h0);
            tick();
        end

        // both reading continuously: MB=4 gives M0x4,M1x4..., MB=1 alternates from M0
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 32'h200, 32'h0, 4'h0, 1'b1, 32'h300, 32'h0, 4'h0);
            check($sformatf("burst4 seq%0d", i), 32'(lastw[0]), ((i / 4) % 2 == 0) ? 32'd1 : 32'd2);
            check($sformatf("burst1 seq%0d", i), 32'(lastw[1]), (i % 2 == 0) ? 32'd1 : 32'd2);
            tick();
        end

        // M1 drops out: M0 granted every cycle
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 32'h200, 32'h0, 4'h0, 1'b0, 32'h300, 32'h0, 4'h0);
            check($sformatf("lone m0 %0d", i), 32'({g0[1], g1[1]}), 32'h2);
            tick();
        end

        // lone M0 read of 0x10
        drive(1'b1, 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rd10 gnt", 32'(g0[0]), 32'h1);
        check("rd10 mem_addr", maddr[0], 32'h10);
        tick();
        idle();
        check("rd10 rvalid", 32'(rv0[0]), 32'h1);
        check("rd10 rdata", rd0[0], 32'hDEAD_BEEF);
        check("rd10 m1 quiet", 32'(rv1[0]) | rd1[0], 32'h0);
        tick();

        // M1 write, M0 idle
        drive(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 32'h34560, 32'hA5, 4'hF);
        check("wr mem_we", 32'(mwe[0]), 32'hF);
        check("wr mem_addr", maddr[0], 32'h34560);
        check("wr mem_wdata", mwd[0], 32'hA5);
        tick();
        idle();
        check("wr no rvalid", 32'({rv0[0], rv1[0]}), 32'h0);
        tick();

        // read attempted during reset is dropped; M0 wins the first tie afterwards
        drive(1'b0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0, 4'h0);
        check("rstrd gnt", 32'(g0[0]), 32'h0);
        tick();
        drive(1'b1, 1'b1, 32'h44, 32'h0, 4'h0, 1'b1, 32'h48, 32'h0, 4'h0);
        check("rstrd rvalid", 32'(rv0[0]), 32'h0);
        check("rstrd tie m0", 32'({g0[0], g1[0]}), 32'h2);
        tick();

        // randomized traffic with occasional reset
        q0 = 1'b0; q1 = 1'b0;
        a0 = '0; d0 = '0; e0 = '0; a1 = '0; d1 = '0; e1 = '0;
        p0 = 50; p1 = 50;
        for (int i = 0; i < 3000; i++) begin
            logic rs;
            if (i % 200 == 0) begin
                p0 = $urandom_range(10, 100);
                p1 = $urandom_range(10, 100);
            end
            // pending ungranted requests usually hold; otherwise new random fields
            if (!(q0 && !g0[0] && $urandom_range(0, 9) != 0)) begin
                q0 = ($urandom_range(1, 100) <= p0);
                a0 = $urandom; d0 = $urandom;
                e0 = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            if (!(q1 && !g1[0] && $urandom_range(0, 9) != 0)) begin
                q1 = ($urandom_range(1, 100) <= p1);
                a1 = $urandom; d1 = $urandom;
                e1 = ($urandom_range(0, 1) != 0) ? 4'h0 : 4'($urandom_range(1, 15));
            end
            rs = ($urandom_range(0, 199) != 0);
            drive(rs, q0, a0, d0, e0, q1, a1, d1, e1);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
